// File: rtl/button_press_decoder.sv
// button_press_decoder
//   Turns synchronized, active-low push buttons into debounced press events.
//   Each channel runs its own FSM and counter. Channels never interact.
//
//   Ports
//     clock        in   rising-edge system clock
//     reset_s2_n   in   asynchronous active-low reset (already synchronized)
//     button_s2_n  in   [NUM_BUTTONS] raw button levels, 0 = pressed
//     held         out  [NUM_BUTTONS] 1 while a debounced press is active
//     short_press  out  [NUM_BUTTONS] 1-cycle pulse on release of a press that never went long
//     long_press   out  [NUM_BUTTONS] 1-cycle pulse when a press reaches the long threshold
//
//   Timing per channel
//     held rises on the (DEBOUNCE_CYCLES+1)th consecutive low sample.
//     long_press fires LONG_PRESS_CYCLES low samples after held rose.
//     held falls, together with any short_press, once the release debounce completes.
module button_press_decoder #(
    parameter int unsigned NUM_BUTTONS       = 3,
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic                   clock,
    input  logic                   reset_s2_n,
    input  logic [NUM_BUTTONS-1:0] button_s2_n,
    output logic [NUM_BUTTONS-1:0] held,
    output logic [NUM_BUTTONS-1:0] short_press,
    output logic [NUM_BUTTONS-1:0] long_press
);

    localparam int unsigned MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                                         DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESS_DEB   = 3'd1,
        ST_PRESSED     = 3'd2,
        ST_LONG        = 3'd3,
        ST_RELEASE_DEB = 3'd4
    } state_t;

    for (genvar ch = 0; ch < NUM_BUTTONS; ch++) begin : g_ch

        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             short_flag;
        logic             short_flag_nxt;
        logic             held_q;
        logic             held_nxt;
        logic             short_q;
        logic             short_nxt;
        logic             long_q;
        logic             long_nxt;
        logic             btn_n;
        logic             deb_done;
        logic             long_done;

        assign btn_n     = button_s2_n[ch];
        assign deb_done  = (cnt == DEB_LAST);
        assign long_done = (cnt == LONG_LAST);

        // State register plus registered outputs; reset discards any press in flight.
        always_ff @(posedge clock or negedge reset_s2_n) begin
            if (!reset_s2_n) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                short_flag <= 1'b0;
                held_q     <= 1'b0;
                short_q    <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                state      <= state_nxt;
                cnt        <= cnt_nxt;
                short_flag <= short_flag_nxt;
                held_q     <= held_nxt;
                short_q    <= short_nxt;
                long_q     <= long_nxt;
            end
        end

        // Next-state and counter; the counter restarts from zero on every state entry.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ST_IDLE: begin
                    if (!btn_n) begin
                        state_nxt = ST_PRESS_DEB;
                        cnt_nxt   = '0;
                    end
                end
                ST_PRESS_DEB: begin
                    if (btn_n) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (deb_done) begin
                        state_nxt = ST_PRESSED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (btn_n) begin
                        state_nxt = ST_RELEASE_DEB;
                        cnt_nxt   = '0;
                    end else if (long_done) begin
                        state_nxt = ST_LONG;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_LONG: begin
                    if (btn_n) begin
                        state_nxt = ST_RELEASE_DEB;
                        cnt_nxt   = '0;
                    end
                end
                ST_RELEASE_DEB: begin
                    // A low sample here is release bounce: restart the debounce window.
                    if (!btn_n) begin
                        cnt_nxt = '0;
                    end else if (deb_done) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Output decode; pulses default low so they never last more than one cycle.
        always_comb begin
            held_nxt       = held_q;
            short_nxt      = 1'b0;
            long_nxt       = 1'b0;
            short_flag_nxt = short_flag;
            case (state)
                ST_PRESS_DEB: begin
                    if (!btn_n && deb_done) begin
                        held_nxt = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // Release wins over a coincident long threshold.
                    if (btn_n) begin
                        short_flag_nxt = 1'b1;
                    end else if (long_done) begin
                        long_nxt = 1'b1;
                    end
                end
                ST_LONG: begin
                    if (btn_n) begin
                        short_flag_nxt = 1'b0;
                    end
                end
                ST_RELEASE_DEB: begin
                    if (btn_n && deb_done) begin
                        held_nxt  = 1'b0;
                        short_nxt = short_flag;
                    end
                end
                ST_IDLE: begin
                end
                default: begin
                    held_nxt       = 1'b0;
                    short_flag_nxt = 1'b0;
                end
            endcase
        end

        assign held[ch]        = held_q;
        assign short_press[ch] = short_q;
        assign long_press[ch]  = long_q;

    end

endmodule
